rf_read_scheduler: RTL and testbench



---
 rtl/rf_read_scheduler_if.sv | 40 ++++
 rtl/rf_read_scheduler.sv | 104 ++++++++++
 tb/tb_rf_read_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_read_scheduler_if.sv
// Issue-stage bundle between the decoder, the writeback path and the register-file read scheduler.
// The slave modport is the scheduler; the master modport is whoever drives decode and writeback.
interface rf_read_scheduler_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(NREG);

  logic             dec_valid;
  logic             dec_ready;
  logic             r_type;
  logic             i_type;
  logic             d_type;
  logic             cb_type;
  logic             b_type;
  logic             d_store;
  logic [IDX_W-1:0] rn;
  logic [IDX_W-1:0] rm;
  logic [IDX_W-1:0] rd_rt;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_rd;
  logic             flush;
  logic             issue;
  logic [NREG-1:0]  Asel;
  logic [NREG-1:0]  Bsel;
  logic [NREG-1:0]  busy_vec;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dec_valid, r_type, i_type, d_type, cb_type, b_type, d_store,
           rn, rm, rd_rt, wb_valid, wb_rd, flush,
    input  dec_ready, issue, Asel, Bsel, busy_vec, stall_cnt
  );

  modport slave (
    input  dec_valid, r_type, i_type, d_type, cb_type, b_type, d_store,
           rn, rm, rd_rt, wb_valid, wb_rd, flush,
    output dec_ready, issue, Asel, Bsel, busy_vec, stall_cnt
  );
endinterface

// File: rtl/rf_read_scheduler.sv
// Register-file read scheduler: busy scoreboard, RAW/WAW stall, registered one-hot read selects.
// The top register index is XZR and never participates in hazards or tracking.
module rf_read_scheduler #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  rf_read_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NREG);
  localparam logic [IDX_W-1:0] XZR = IDX_W'(NREG - 1);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = {NREG{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [NREG-1:0]  asel_q, asel_d;
  logic [NREG-1:0]  bsel_q, bsel_d;
  logic             issue_q, issue_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             src_a, src_b, dst_en;
  logic [IDX_W-1:0] b_idx;
  logic [NREG-1:0]  wb_mask, eff_busy;
  logic             haz_a, haz_b, haz_d, hazard;
  logic             stall_ev, fire;

  // Decode operand roles, evaluate hazards and form all next-state values.
  always_comb begin
    src_a    = bus.r_type | bus.i_type | bus.d_type;
    src_b    = bus.r_type | (bus.d_type & bus.d_store) | bus.cb_type;
    dst_en   = bus.r_type | bus.i_type | (bus.d_type & ~bus.d_store);
    b_idx    = bus.r_type ? bus.rm : bus.rd_rt;

    // A same-cycle writeback frees its register because the file writes before it reads.
    wb_mask  = bus.wb_valid ? onehot(bus.wb_rd) : {NREG{1'b0}};
    eff_busy = busy_q & ~wb_mask;

    haz_a    = src_a  & (bus.rn    != XZR) & eff_busy[bus.rn];
    haz_b    = src_b  & (b_idx     != XZR) & eff_busy[b_idx];
    haz_d    = dst_en & (bus.rd_rt != XZR) & eff_busy[bus.rd_rt];
    hazard   = haz_a | haz_b | haz_d;

    stall_ev = bus.dec_valid & hazard & ~bus.flush;
    fire     = bus.dec_valid & ~hazard & ~bus.flush;

    busy_d   = eff_busy | ((fire & dst_en) ? onehot(bus.rd_rt) : {NREG{1'b0}});
    busy_d[XZR] = 1'b0;

    asel_d   = (fire & src_a) ? onehot(bus.rn) : {NREG{1'b0}};
    bsel_d   = (fire & src_b) ? onehot(b_idx)  : {NREG{1'b0}};
    issue_d  = fire;

    if (stall_ev && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    state_d = state_q;
    case (state_q)
      RUN:     state_d = stall_ev ? STALL : RUN;
      STALL:   state_d = stall_ev ? STALL : RUN;
      default: state_d = RUN;
    endcase
  end

  // State, scoreboard and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      busy_q  <= {NREG{1'b0}};
      asel_q  <= {NREG{1'b0}};
      bsel_q  <= {NREG{1'b0}};
      issue_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      issue_q <= issue_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dec_ready = ~hazard;
  assign bus.issue     = issue_q;
  assign bus.Asel      = asel_q;
  assign bus.Bsel      = bsel_q;
  assign bus.busy_vec  = busy_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_rf_read_scheduler.sv
// Self-checking bench for rf_read_scheduler: directed scenarios plus randomized traffic
// checked against a per-register busy model built from the operand-role rules.
module tb_rf_read_scheduler;
  localparam int NREG  = 32;
  localparam int CNT_W = 16;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CB = 4, K_B = 5;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  rf_read_scheduler_if #(.NREG(NREG), .CNT_W(CNT_W)) bus ();

  rf_read_scheduler #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_busy[NREG];
  int          m_cnt;
  bit          m_issue;
  logic [31:0] m_asel, m_bsel;
  bit          m_stalled;

  // Currently driven decode/writeback fields
  int cur_kind, cur_rn, cur_rm, cur_rd, cur_wbrd;
  bit cur_valid, cur_wbv, cur_flush;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit blocked(input int r);
    if (r < 0 || r == 31) return 1'b0;
    if (cur_wbv && cur_wbrd == r) return 1'b0;
    return m_busy[r];
  endfunction

  task automatic drive(input int kind, input int rn, input int rm, input int rd,
                       input bit valid, input bit wbv, input int wbrd, input bit fl);
    cur_kind = kind; cur_rn = rn; cur_rm = rm; cur_rd = rd;
    cur_valid = valid; cur_wbv = wbv; cur_wbrd = wbrd; cur_flush = fl;
    bus.r_type  = (kind == K_R);
    bus.i_type  = (kind == K_I);
    bus.d_type  = (kind == K_LD) || (kind == K_ST);
    bus.d_store = (kind == K_ST);
    bus.cb_type = (kind == K_CB);
    bus.b_type  = (kind == K_B);
    bus.rn      = 5'(rn);
    bus.rm      = 5'(rm);
    bus.rd_rt   = 5'(rd);
    bus.dec_valid = valid;
    bus.wb_valid  = wbv;
    bus.wb_rd     = 5'(wbrd);
    bus.flush     = fl;
  endtask

  // One clock: check dec_ready, advance the model, check registered outputs after the edge.
  task automatic step();
    int sa, sb, dst;
    bit hz, fire;
    sa = -1; sb = -1; dst = -1;
    case (cur_kind)
      K_R:     begin sa = cur_rn; sb = cur_rm; dst = cur_rd; end
      K_I:     begin sa = cur_rn; dst = cur_rd; end
      K_LD:    begin sa = cur_rn; dst = cur_rd; end
      K_ST:    begin sa = cur_rn; sb = cur_rd; end
      K_CB:    sb = cur_rd;
      default: ;
    endcase
    #1;
    hz = blocked(sa) || blocked(sb) || blocked(dst);
    chk("dec_ready", {63'b0, bus.dec_ready}, {63'b0, !hz});
    fire      = cur_valid && !hz && !cur_flush;
    m_stalled = cur_valid && hz && !cur_flush;
    if (m_stalled && m_cnt < 65535) m_cnt++;
    if (cur_wbv) m_busy[cur_wbrd] = 1'b0;
    if (fire && dst >= 0 && dst != 31) m_busy[dst] = 1'b1;
    m_issue = fire;
    m_asel  = (fire && sa >= 0) ? (32'd1 << sa) : 32'd0;
    m_bsel  = (fire && sb >= 0) ? (32'd1 << sb) : 32'd0;
    @(posedge clk);
    #1;
    chk("issue",     {63'b0, bus.issue},     {63'b0, m_issue});
    chk("Asel",      {32'b0, bus.Asel},      {32'b0, m_asel});
    chk("Bsel",      {32'b0, bus.Bsel},      {32'b0, m_bsel});
    chk("busy_vec",  {32'b0, bus.busy_vec},  {32'b0, model_busy()});
    chk("stall_cnt", {48'b0, bus.stall_cnt}, 64'(m_cnt));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_cnt = 0; m_issue = 1'b0; m_asel = 32'd0; m_bsel = 32'd0; m_stalled = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_issue"}, {63'b0, bus.issue},     64'd0);
    chk({tag, "_Asel"},  {32'b0, bus.Asel},      64'd0);
    chk({tag, "_Bsel"},  {32'b0, bus.Bsel},      64'd0);
    chk({tag, "_busy"},  {32'b0, bus.busy_vec},  64'd0);
    chk({tag, "_cnt"},   {48'b0, bus.stall_cnt}, 64'd0);
  endtask

  task automatic do_reset();
    drive(K_B, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_zero("rst");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int kind, rn, rm, rd;
    bit valid;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    model_clear();
    do_reset();

    // ADD X1,X2,X3
    drive(K_R, 2, 3, 1, 1'b1, 1'b0, 0, 1'b0); step();
    chk("add_Asel", {32'b0, bus.Asel}, 64'h4);
    chk("add_Bsel", {32'b0, bus.Bsel}, 64'h8);
    chk("add_busy", {32'b0, bus.busy_vec}, 64'h2);

    // LDUR X5,[X1] then dependent ADD X6,X5,X7
    do_reset();
    drive(K_LD, 1, 0, 5, 1'b1, 1'b0, 0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      drive(K_R, 5, 7, 6, 1'b1, 1'b0, 0, 1'b0); step();
    end
    chk("raw_cnt3", {48'b0, bus.stall_cnt}, 64'd3);
    drive(K_R, 5, 7, 6, 1'b1, 1'b1, 5, 1'b0); step();
    chk("raw_Asel", {32'b0, bus.Asel}, 64'h20);
    chk("raw_Bsel", {32'b0, bus.Bsel}, 64'h80);

    // Writeback to X4 in the same cycle a new writer to X4 fires
    do_reset();
    drive(K_I, 0, 0, 4, 1'b1, 1'b0, 0, 1'b0); step();
    drive(K_I, 0, 0, 4, 1'b1, 1'b1, 4, 1'b0); step();
    chk("waw_set_wins", {63'b0, bus.busy_vec[4]}, 64'd1);

    // ADDI X31,X31,#1 twice
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(K_I, 31, 0, 31, 1'b1, 1'b0, 0, 1'b0); step();
      chk("xzr_Asel", {32'b0, bus.Asel}, 64'h8000_0000);
      chk("xzr_busy", {32'b0, bus.busy_vec}, 64'd0);
    end

    // Stalled instruction dropped by flush
    do_reset();
    drive(K_LD, 1, 0, 5, 1'b1, 1'b0, 0, 1'b0); step();
    drive(K_R, 5, 7, 6, 1'b1, 1'b0, 0, 1'b0); step();
    drive(K_R, 5, 7, 6, 1'b1, 1'b0, 0, 1'b1); step();
    chk("flush_issue", {63'b0, bus.issue}, 64'd0);
    chk("flush_busy",  {32'b0, bus.busy_vec}, 64'h20);
    chk("flush_cnt",   {48'b0, bus.stall_cnt}, 64'd1);

    // Reset asserted mid-stall with X1 and X5 busy
    do_reset();
    drive(K_I, 0, 0, 1, 1'b1, 1'b0, 0, 1'b0); step();
    drive(K_I, 0, 0, 5, 1'b1, 1'b0, 0, 1'b0); step();
    drive(K_R, 5, 0, 2, 1'b1, 1'b0, 0, 1'b0); step();
    chk("pre_rst_busy", {32'b0, bus.busy_vec}, 64'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    do_reset();

    // Randomized traffic against the model
    kind = K_B; rn = 0; rm = 0; rd = 0; valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!m_stalled) begin
        kind  = $urandom_range(0, 5);
        rn    = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
        rm    = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
        rd    = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
        valid = ($urandom_range(0, 4) != 0);
      end
      drive(kind, rn, rm, rd, valid, ($urandom_range(0, 9) < 4),
            $urandom_range(0, 7), ($urandom_range(0, 9) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
